// File: rtl/csr_pkg.sv
// Shared CSR addresses, Zicsr opcode and controller state encodings.
package csr_pkg;

  localparam logic [11:0] MSTATUS = 12'h300;
  localparam logic [11:0] MTVEC   = 12'h305;
  localparam logic [11:0] MEPC    = 12'h341;
  localparam logic [11:0] MCAUSE  = 12'h342;
  localparam logic [11:0] MTVAL   = 12'h343;
  localparam logic [11:0] FFLAGS  = 12'h001;
  localparam logic [11:0] FRM     = 12'h002;
  localparam logic [11:0] FCSR    = 12'h003;

  typedef enum logic [2:0] {
    CSRRW  = 3'b001,
    CSRRS  = 3'b010,
    CSRRC  = 3'b011,
    CSRRWI = 3'b101,
    CSRRSI = 3'b110,
    CSRRCI = 3'b111
  } csr_op_e;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    RESP,
    FRD,
    FWR
  } csr_state_e;

  // funct3 000 and 100 are not Zicsr encodings
  function automatic logic csr_funct3_legal(input logic [2:0] f3);
    return f3[1:0] != 2'b00;
  endfunction

  function automatic logic csr_implemented(input logic [11:0] addr);
    case (addr)
      MSTATUS, MTVEC, MEPC, MCAUSE, MTVAL, FFLAGS, FRM, FCSR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_alu.sv
// Zicsr new-value computation; flags writes that the ISA says must not happen.
module csr_alu
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  csr_op_e           op_i,
  input  logic [XLEN-1:0]   old_i,
  input  logic [XLEN-1:0]   operand_i,
  input  logic              rs1_zero_i,
  output logic [XLEN-1:0]   new_o,
  output logic              suppress_o
);

  always_comb begin
    new_o      = operand_i;
    suppress_o = 1'b0;
    case (op_i)
      CSRRW, CSRRWI: new_o = operand_i;
      CSRRS: begin
        new_o      = old_i | operand_i;
        suppress_o = rs1_zero_i;
      end
      CSRRC: begin
        new_o      = old_i & ~operand_i;
        suppress_o = rs1_zero_i;
      end
      // immediate set/clear forms skip the write when zimm is zero
      CSRRSI: begin
        new_o      = old_i | operand_i;
        suppress_o = (operand_i == '0);
      end
      CSRRCI: begin
        new_o      = old_i & ~operand_i;
        suppress_o = (operand_i == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_ctrl.sv
// Zicsr read-modify-write controller with FPU flag merging into fflags.
// Response 3/2/1 cycles after accept (write/suppressed/illegal); resp held until resp_ready.
module csr_ctrl
  import csr_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int FLAGW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [11:0]       req_addr,
  input  logic [XLEN-1:0]   req_rs1_data,
  input  logic [4:0]        req_zimm,
  input  logic              req_rs1_zero,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rd_data,
  output logic              resp_illegal,
  input  logic              fpu_flags_valid,
  input  logic [FLAGW-1:0]  fpu_flags,
  output logic [11:0]       csr_raddr,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic              csr_we,
  output logic [11:0]       csr_waddr,
  output logic [XLEN-1:0]   csr_wdata
);

  csr_state_e        state_q, state_d;
  csr_op_e           op_q, op_d;
  logic [11:0]       addr_q, addr_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              rs1z_q, rs1z_d;
  logic [XLEN-1:0]   old_q, old_d;
  logic [XLEN-1:0]   new_q, new_d;
  logic              ill_q, ill_d;
  logic [FLAGW-1:0]  pend_q, pend_d;
  logic [FLAGW-1:0]  snap_q, snap_d;
  logic [FLAGW-1:0]  merged_q, merged_d;
  logic [FLAGW-1:0]  flag_in;
  logic [XLEN-1:0]   alu_new;
  logic              alu_sup;

  csr_alu #(.XLEN(XLEN)) u_alu (
    .op_i       (op_q),
    .old_i      (csr_rdata),
    .operand_i  (opnd_q),
    .rs1_zero_i (rs1z_q),
    .new_o      (alu_new),
    .suppress_o (alu_sup)
  );

  assign flag_in = fpu_flags_valid ? fpu_flags : '0;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    opnd_d       = opnd_q;
    rs1z_d       = rs1z_q;
    old_d        = old_q;
    new_d        = new_q;
    ill_d        = ill_q;
    snap_d       = snap_q;
    merged_d     = merged_q;
    pend_d       = pend_q | flag_in;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_rd_data = '0;
    resp_illegal = 1'b0;
    csr_raddr    = '0;
    csr_we       = 1'b0;
    csr_waddr    = '0;
    csr_wdata    = '0;

    case (state_q)
      IDLE: begin
        // pending flag merges win over new instructions
        if (pend_q != '0) begin
          state_d = FRD;
        end else begin
          req_ready = 1'b1;
          if (req_valid) begin
            addr_d = req_addr;
            opnd_d = req_funct3[2] ? {{(XLEN-5){1'b0}}, req_zimm} : req_rs1_data;
            rs1z_d = req_rs1_zero;
            if (csr_funct3_legal(req_funct3) && csr_implemented(req_addr)) begin
              op_d    = csr_op_e'(req_funct3);
              ill_d   = 1'b0;
              state_d = READ;
            end else begin
              ill_d   = 1'b1;
              old_d   = '0;
              state_d = RESP;
            end
          end
        end
      end
      READ: begin
        csr_raddr = addr_q;
        old_d     = csr_rdata;
        new_d     = alu_new;
        state_d   = alu_sup ? RESP : WRITE;
      end
      WRITE: begin
        csr_we    = 1'b1;
        csr_waddr = addr_q;
        csr_wdata = new_q;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid   = 1'b1;
        resp_rd_data = old_q;
        resp_illegal = ill_q;
        if (resp_ready) state_d = IDLE;
      end
      FRD: begin
        csr_raddr = FFLAGS;
        snap_d    = pend_q;
        merged_d  = csr_rdata[FLAGW-1:0] | pend_q;
        state_d   = FWR;
      end
      FWR: begin
        csr_we    = 1'b1;
        csr_waddr = FFLAGS;
        csr_wdata = {{(XLEN-FLAGW){1'b0}}, merged_q};
        // only the snapshotted flags are retired; same-cycle arrivals stay pending
        pend_d    = (pend_q & ~snap_q) | flag_in;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      req_ready    = 1'b0;
      resp_valid   = 1'b0;
      resp_rd_data = '0;
      resp_illegal = 1'b0;
      csr_raddr    = '0;
      csr_we       = 1'b0;
      csr_waddr    = '0;
      csr_wdata    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= CSRRW;
      addr_q   <= '0;
      opnd_q   <= '0;
      rs1z_q   <= 1'b0;
      old_q    <= '0;
      new_q    <= '0;
      ill_q    <= 1'b0;
      pend_q   <= '0;
      snap_q   <= '0;
      merged_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      opnd_q   <= opnd_d;
      rs1z_q   <= rs1z_d;
      old_q    <= old_d;
      new_q    <= new_d;
      ill_q    <= ill_d;
      pend_q   <= pend_d;
      snap_q   <= snap_d;
      merged_q <= merged_d;
    end
  end

endmodule

// File: tb/tb_csr_ctrl.sv
// Scoreboard bench for csr_ctrl: random Zicsr traffic against an ISA-level CSR model.
module tb_csr_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = '0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_rs1_data = '0;
  logic [4:0]  req_zimm = '0;
  logic        req_rs1_zero = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rd_data;
  logic        resp_illegal;
  logic        fpu_flags_valid = 1'b0;
  logic [4:0]  fpu_flags = '0;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;

  always #5 clk = ~clk;

  csr_ctrl #(.XLEN(32), .FLAGW(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_rs1_data(req_rs1_data), .req_zimm(req_zimm),
    .req_rs1_zero(req_rs1_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd_data(resp_rd_data),
    .resp_illegal(resp_illegal),
    .fpu_flags_valid(fpu_flags_valid), .fpu_flags(fpu_flags),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_we(csr_we),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata)
  );

  // register file behind the controller
  logic [31:0] rf [0:4095];
  assign csr_rdata = rf[csr_raddr];
  always @(posedge clk) if (csr_we) rf[csr_waddr] = csr_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] rd; logic ill; int due; } resp_t;
  typedef struct { logic [11:0] addr; logic [31:0] data; int due; } wr_t;
  resp_t rq[$];
  wr_t   wq[$];
  logic [31:0] ref_csr [0:4095];
  logic [11:0] addr_tab [0:10];

  int   n_vec = 0, n_err = 0;
  bit   flag_mode = 1'b0, rr_rand = 1'b0;
  logic rr_val = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s", nm);
  endtask

  // ISA-level reference: what rd returns, whether and what gets written, and when
  task automatic model(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                       input logic [4:0] zimm, input logic rs1z);
    logic [31:0] op, old, nv;
    bit wr, legal;
    legal = (f3[1:0] != 2'b00) &&
            (a inside {12'h300, 12'h305, 12'h341, 12'h342, 12'h343, 12'h001, 12'h002, 12'h003});
    if (!legal) begin
      rq.push_back('{rd: 32'h0, ill: 1'b1, due: cyc + 1});
      return;
    end
    old = ref_csr[a];
    op  = f3[2] ? {27'b0, zimm} : rs1;
    nv  = op;
    wr  = 1'b1;
    if (f3[1:0] == 2'b10) nv = old | op;
    if (f3[1:0] == 2'b11) nv = old & ~op;
    if (f3[1:0] != 2'b01) wr = f3[2] ? (zimm != 0) : !rs1z;
    rq.push_back('{rd: old, ill: 1'b0, due: cyc + (wr ? 3 : 2)});
    if (wr) begin
      wq.push_back('{addr: a, data: nv, due: cyc + 2});
      ref_csr[a] = nv;
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                       input logic [4:0] zimm, input logic rs1z);
    bit ok = 1'b0;
    @(posedge clk); #1;
    req_funct3 = f3; req_addr = a; req_rs1_data = rs1; req_zimm = zimm; req_rs1_zero = rs1z;
    req_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail("accept_timeout");
    else model(f3, a, rs1, zimm, rs1z);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (rq.size() == 0 && wq.size() == 0 && !resp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) fail("drain_timeout");
  endtask

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail("ready_timeout");
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'h0);
    chk({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'h0);
    chk({tag, "_resp_rd"}, resp_rd_data, 32'h0);
    chk({tag, "_resp_ill"}, {31'b0, resp_illegal}, 32'h0);
    chk({tag, "_we"}, {31'b0, csr_we}, 32'h0);
    chk({tag, "_raddr"}, {20'b0, csr_raddr}, 32'h0);
    chk({tag, "_waddr"}, {20'b0, csr_waddr}, 32'h0);
    chk({tag, "_wdata"}, csr_wdata, 32'h0);
  endtask

  always @(posedge clk) begin
    #1;
    resp_ready = rr_rand ? ($urandom_range(0, 3) != 0) : rr_val;
  end

  // monitor: write port and response port checked against the scoreboard queues
  logic        hold_prev = 1'b0, in_resp = 1'b0, prev_ill;
  logic [31:0] prev_rd;
  always @(negedge clk) begin
    wr_t   w;
    resp_t e;
    if (rst) begin
      in_resp   = 1'b0;
      hold_prev = 1'b0;
    end else begin
      if (csr_we) begin
        if (flag_mode && wq.size() == 0) begin
          chk("fwr_addr", {20'b0, csr_waddr}, 32'h1);
          chk("fwr_upper", csr_wdata & 32'hFFFF_FFE0, 32'h0);
        end else if (wq.size() == 0) begin
          fail("unexpected_csr_we");
        end else begin
          w = wq.pop_front();
          chk("wr_addr", {20'b0, csr_waddr}, {20'b0, w.addr});
          chk("wr_data", csr_wdata, w.data);
          chk("wr_cycle", cyc, w.due);
        end
      end
      if (resp_valid) begin
        chk("ready_in_resp", {31'b0, req_ready}, 32'h0);
        if (!in_resp) begin
          in_resp = 1'b1;
          if (rq.size() == 0) fail("unexpected_resp");
          else chk("resp_latency", cyc, rq[0].due);
        end
        if (hold_prev) begin
          chk("hold_rd", resp_rd_data, prev_rd);
          chk("hold_ill", {31'b0, resp_illegal}, {31'b0, prev_ill});
        end
        if (resp_ready) begin
          if (rq.size() != 0) begin
            e = rq.pop_front();
            chk("resp_rd", resp_rd_data, e.rd);
            chk("resp_ill", {31'b0, resp_illegal}, {31'b0, e.ill});
          end
          in_resp   = 1'b0;
          hold_prev = 1'b0;
        end else begin
          hold_prev = 1'b1;
          prev_rd   = resp_rd_data;
          prev_ill  = resp_illegal;
        end
      end else begin
        if (hold_prev) fail("resp_dropped");
        hold_prev = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [2:0]  f3;
    logic [11:0] a;
    logic [4:0]  z;
    for (int i = 0; i < 4096; i++) begin rf[i] = 32'h0; ref_csr[i] = 32'h0; end
    addr_tab[0] = 12'h300; addr_tab[1] = 12'h305; addr_tab[2] = 12'h341; addr_tab[3] = 12'h342;
    addr_tab[4] = 12'h343; addr_tab[5] = 12'h001; addr_tab[6] = 12'h002; addr_tab[7] = 12'h003;
    addr_tab[8] = 12'h7C0; addr_tab[9] = 12'h344; addr_tab[10] = 12'h000;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // CSRRW mtvec then read back with CSRRS rs1=x0
    issue(3'b001, 12'h305, 32'h8000_0100, 5'd0, 1'b0);
    issue(3'b010, 12'h305, 32'hFFFF_FFFF, 5'd0, 1'b1);
    drain();
    chk("mtvec_rf", rf[12'h305], 32'h8000_0100);

    // CSRRS mstatus 0x8, then CSRRCI mstatus 0x8
    issue(3'b010, 12'h300, 32'h8, 5'd0, 1'b0);
    issue(3'b111, 12'h300, 32'h0, 5'd8, 1'b0);
    drain();
    chk("mstatus_rf", rf[12'h300], 32'h0);

    // two flag strobes back to back while idle
    flag_mode = 1'b1;
    @(posedge clk); #1;
    fpu_flags_valid = 1'b1; fpu_flags = 5'h01;
    @(posedge clk); #1;
    fpu_flags = 5'h10;
    @(negedge clk);
    chk("flag_blocks_ready", {31'b0, req_ready}, 32'h0);
    @(posedge clk); #1;
    fpu_flags_valid = 1'b0;
    wait_ready();
    chk("fflags_merge1", rf[12'h001], 32'h11);
    ref_csr[12'h001] = (ref_csr[12'h001] & 32'h1F) | 32'h11;

    // second strobe lands in the cycle fflags is being written back
    @(posedge clk); #1;
    fpu_flags_valid = 1'b1; fpu_flags = 5'h02;
    @(posedge clk); #1;
    fpu_flags_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    fpu_flags_valid = 1'b1; fpu_flags = 5'h04;
    @(posedge clk); #1;
    fpu_flags_valid = 1'b0;
    wait_ready();
    repeat (3) @(negedge clk);
    chk("ready_after_merge", {31'b0, req_ready}, 32'h1);
    chk("fflags_merge2", rf[12'h001], 32'h17);
    ref_csr[12'h001] = (ref_csr[12'h001] & 32'h1F) | 32'h06;
    flag_mode = 1'b0;

    // CSRRSI fflags with zimm=0: read only
    issue(3'b110, 12'h001, 32'h0, 5'd0, 1'b0);
    // illegal funct3 and unimplemented address
    issue(3'b100, 12'h300, 32'h1234, 5'd3, 1'b0);
    issue(3'b001, 12'h7C0, 32'h1234, 5'd3, 1'b0);
    drain();

    // consumer stalls the response for several cycles
    rr_val = 1'b0;
    issue(3'b001, 12'h341, 32'hCAFE_F00D, 5'd0, 1'b0);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (resp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) fail("stall_resp_timeout");
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, resp_valid}, 32'h1);
    end
    rr_val = 1'b1;
    drain();

    // reset while an accepted write sits in READ
    @(posedge clk); #1;
    req_funct3 = 3'b001; req_addr = 12'h342; req_rs1_data = 32'hDEAD_BEEF; req_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail("rst_accept_timeout");
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    issue(3'b010, 12'h342, 32'h0, 5'd0, 1'b1);
    drain();
    chk("mcause_untouched", rf[12'h342], ref_csr[12'h342]);

    // randomized traffic with random consumer backpressure
    rr_rand = 1'b1;
    repeat (300) begin
      f3 = 3'($urandom_range(0, 7));
      a  = addr_tab[$urandom_range(0, 10)];
      z  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      issue(f3, a, $urandom, z, $urandom_range(0, 3) == 0);
    end
    drain();
    rr_rand = 1'b0;

    for (int i = 0; i < 8; i++) chk("final_rf", rf[addr_tab[i]], ref_csr[addr_tab[i]]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/csr_ctrl.md
Name: csr_ctrl

Overview:
Control stage directly upstream of the CSR register file. It executes Zicsr instructions (CSRRW/RS/RC and their immediate forms) as a read-modify-write sequence over the register file's separate read and write ports, and returns the old CSR value for rd. It also accumulates FPU exception flags and merges them into fflags (0x001) with its own read-modify-write sequence.

Parameters:
XLEN, 32, data width of CSR values and rs1 operand
FLAGW, 5, width of FPU exception flag vector (NV,DZ,OF,UF,NX)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
req_valid  in  1  CSR instruction request valid
req_ready  out  1  controller can accept a request
req_funct3  in  3  Zicsr funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI)
req_addr  in  12  CSR address
req_rs1_data  in  XLEN  rs1 operand (register forms)
req_zimm  in  5  zero-extended immediate (immediate forms)
req_rs1_zero  in  1  rs1 index is x0 (register forms only)
resp_valid  out  1  result valid
resp_ready  in  1  consumer accepts result
resp_rd_data  out  XLEN  old CSR value
resp_illegal  out  1  illegal funct3 or unimplemented address
fpu_flags_valid  in  1  FPU flag update strobe
fpu_flags  in  FLAGW  exception flags raised by the FPU
csr_raddr  out  12  to the register file read address
csr_rdata  in  XLEN  from the register file (combinational)
csr_we  out  1  to the register file write enable
csr_waddr  out  12  to the register file write address
csr_wdata  out  XLEN  to the register file write data

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, pend_flags=0, and all outputs 0 (req_ready=0 during the reset cycle, resp_*=0, csr_we=0, csr_raddr=0, csr_waddr=0, csr_wdata=0).
- FSM states: IDLE, READ, WRITE, RESP, FRD, FWR.
- IDLE: if pend_flags≠0, go to FRD with req_ready=0; flag merge takes priority. Otherwise req_ready=1, and on req_valid go to READ, latching funct3, addr and operand (zimm or rs1_data).
- Illegal request: funct3 ∈ {000,100}, or addr not in {0x300,0x305,0x341,0x342,0x343,0x001,0x002,0x003}. Go to RESP directly with resp_illegal=1 and rd_data=0. No csr_we is issued.
- READ: csr_raddr=addr. Capture csr_rdata into old. Compute new value: RW uses op; RS uses old|op; RC uses old&~op.
- Write suppression: for RS/RC, no write if req_rs1_zero=1; for RSI/RCI, no write if zimm=0. When suppressed, go to RESP; otherwise go to WRITE.
- WRITE: csr_we=1 for exactly one cycle, with csr_waddr=addr and csr_wdata=new. Then go to RESP.
- RESP: resp_valid=1 and outputs are held stable until resp_ready=1. The handshake cycle returns to IDLE.
- Latency: accept at cycle T, READ at T+1, WRITE at T+2, resp_valid at T+3. With suppression or an illegal request, resp_valid is at T+2 or T+1 respectively.
- Flag merge: pend_flags |= fpu_flags on every fpu_flags_valid, in any state.
  - FRD: csr_raddr=0x001. Snapshot snap=pend_flags. Form merged = rdata[4:0]|snap.
  - FWR: csr_we=1, csr_waddr=0x001, csr_wdata={27'b0,merged}. Clear pend_flags &= ~snap, then OR in any flags arriving in the same cycle; no flag is lost. Return to IDLE.
- csr_we is never asserted outside WRITE and FWR. csr_raddr=0 outside READ and FRD.
- Reset mid-sequence: abandon the operation with no csr_we and no response, and discard pend_flags.
- Back-to-back: a new request is accepted no earlier than the cycle after the RESP handshake, so the register file's mid-cycle write is visible to the next READ.

Decomposition:
- Package csr_pkg holds:
  - CSR address localparams (MSTATUS=0x300, MTVEC=0x305, MEPC=0x341, MCAUSE=0x342, MTVAL=0x343, FFLAGS=0x001, FRM=0x002, FCSR=0x003).
  - Enum csr_op_e for funct3 values.
  - FSM enum csr_state_e.
  - Function csr_implemented(addr).
- One natural combinational sub-module, csr_alu: (op, old, operand) → new value plus a write-suppress flag.

Test Plan:
- CSRRW 0x305, rs1=0x8000_0100 at reset value 0 → csr_we at T+2 with waddr=0x305, wdata=0x80000100; resp at T+3 with rd=0; a subsequent CSRRS with rs1_zero reads back 0x80000100.
- CSRRS 0x300, rs1=0x8, followed by CSRRCI 0x300, zimm=0x8 → first returns 0, writes 0x8; second returns 0x8, writes 0x0.
- CSRRSI 0x001 with zimm=0 → no csr_we, rd=current fflags, resp_valid at T+2.
- funct3=100, or addr=0x7C0 → resp_illegal=1, rd=0, no csr_we, resp_valid at T+1.
- fpu_flags_valid with flags=0x01, then 0x10 one cycle later, while idle → req_ready=0; FWR writes 0x001; fflags ends at 0x11, possibly via two merges; pend_flags ends at 0.
- resp_ready held low for 5 cycles during RESP → resp outputs stable and req_ready=0. Also, rst asserted in WRITE-pending READ → no csr_we, and all outputs are 0 the next cycle.
